p2s_arbiter: RTL and testbench

- Shares one parallel2serial converter among NUM_REQ requesters (e.g. 7-segment display word and LED word on the shared serial shift chain).
- Round-robin arbitration; latches the winner's parallel word, issues start, waits for finish, returns a per-requester done pulse.
- Watchdog aborts a transfer whose finish never arrives.
- Sits between the display/LED drivers and the converter instance in the Sys layer.

---
 rtl/p2s_arbiter.sv | 149 ++++++++++++++
 tb/tb_p2s_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p2s_arbiter.sv
// p2s_arbiter: round-robin owner selection for one shared parallel-to-serial
// converter. The winner's word is latched at launch, a one-cycle start is
// issued, and the owner gets a done pulse on finish or on watchdog abort.
module p2s_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_BITS      = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int SEL_BITS      = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic                         err,
  output logic [SEL_BITS-1:0]          sel,
  output logic                         p2s_start,
  output logic [DATA_BITS-1:0]         p2s_data,
  input  logic                         p2s_busy,
  input  logic                         p2s_finish
);

  // Watchdog width holds values 0..TIMEOUT_CYCLES-1.
  localparam int WD_BITS = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_BITS-1:0] WD_LAST = WD_BITS'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t                state, state_next;
  logic [SEL_BITS-1:0]   last, last_next;
  logic [SEL_BITS-1:0]   sel_next;
  logic [NUM_REQ-1:0]    grant_next, done_next;
  logic                  err_next, start_next;
  logic [DATA_BITS-1:0]  data_next;
  logic [WD_BITS-1:0]    wd, wd_next;
  logic                  abort, abort_next;

  logic                  hi_found, lo_found;
  logic [SEL_BITS-1:0]   hi_idx, lo_idx, winner;
  logic [DATA_BITS-1:0]  hi_word, lo_word, winner_word;

  // The converter busy flag never gates the FSM; it is only observed.
  logic                  busy_unused;
  assign busy_unused = p2s_busy;

  // Round-robin search: lowest requester above the last owner, else wrap to the lowest overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    hi_word  = '0;
    lo_word  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (i > int'(last))) begin
        hi_found = 1'b1;
        hi_idx   = SEL_BITS'(i);
        hi_word  = req_data[i*DATA_BITS +: DATA_BITS];
      end
      if (req[i]) begin
        lo_found = 1'b1;
        lo_idx   = SEL_BITS'(i);
        lo_word  = req_data[i*DATA_BITS +: DATA_BITS];
      end
    end
    winner      = hi_found ? hi_idx : lo_idx;
    winner_word = hi_found ? hi_word : lo_word;
  end

  // Next-state and registered-output decode; everything holds unless a state says otherwise.
  always_comb begin
    state_next = state;
    last_next  = last;
    sel_next   = sel;
    grant_next = grant;
    done_next  = '0;
    err_next   = 1'b0;
    start_next = 1'b0;
    data_next  = p2s_data;
    wd_next    = wd;
    abort_next = abort;
    case (state)
      IDLE: begin
        if (lo_found) begin
          grant_next         = '0;
          grant_next[winner] = 1'b1;
          sel_next           = winner;
          data_next          = winner_word;
          start_next         = 1'b1;
          state_next         = WAIT;
        end
      end
      WAIT: begin
        wd_next = wd + WD_BITS'(1);
        if (p2s_finish) begin
          state_next = DONE;
        end else if (wd == WD_LAST) begin
          abort_next = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done_next[sel] = 1'b1;
        err_next       = abort;
        grant_next     = '0;
        last_next      = sel;
        wd_next        = '0;
        abort_next     = 1'b0;
        state_next     = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset parks requester NUM_REQ-1 as last so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= SEL_BITS'(NUM_REQ - 1);
      sel       <= '0;
      grant     <= '0;
      done      <= '0;
      err       <= 1'b0;
      p2s_start <= 1'b0;
      p2s_data  <= '0;
      wd        <= '0;
      abort     <= 1'b0;
    end else begin
      state     <= state_next;
      last      <= last_next;
      sel       <= sel_next;
      grant     <= grant_next;
      done      <= done_next;
      err       <= err_next;
      p2s_start <= start_next;
      p2s_data  <= data_next;
      wd        <= wd_next;
      abort     <= abort_next;
    end
  end

endmodule

// File: tb/tb_p2s_arbiter.sv
// tb_p2s_arbiter: directed scenarios for the converter arbiter with a
// behavioural converter and a queue of expected launches.
module tb_p2s_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int TO = 48;
  localparam int SW = $clog2(N);

  typedef struct {
    int          idx;
    logic [DW-1:0] word;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    grant, done;
  logic            err;
  logic [SW-1:0]   sel;
  logic            p2s_start;
  logic [DW-1:0]   p2s_data;
  logic            p2s_busy, p2s_finish;

  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   fin_cyc    = 0;
  int   start_cyc  = 0;
  int   model_last = N - 1;
  int   fin_delay  = 40;
  int   conv_cnt;
  logic conv_active;
  exp_t sb[$];

  p2s_arbiter #(.NUM_REQ(N), .DATA_BITS(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .grant(grant), .done(done), .err(err), .sel(sel),
    .p2s_start(p2s_start), .p2s_data(p2s_data),
    .p2s_busy(p2s_busy), .p2s_finish(p2s_finish)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Remember when the converter last raised finish.
  always @(negedge clk) if (p2s_finish === 1'b1) fin_cyc <= cyc;

  // Converter model: busy after start, finish fin_delay cycles later (0 = never).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_active <= 1'b0;
      conv_cnt    <= 0;
      p2s_busy    <= 1'b0;
      p2s_finish  <= 1'b0;
    end else begin
      p2s_finish <= 1'b0;
      if (p2s_start) begin
        conv_active <= 1'b1;
        conv_cnt    <= 1;
        p2s_busy    <= 1'b1;
      end else if (conv_active) begin
        if (fin_delay != 0 && conv_cnt == fin_delay) begin
          p2s_finish  <= 1'b1;
          conv_active <= 1'b0;
          p2s_busy    <= 1'b0;
        end else begin
          conv_cnt <= conv_cnt + 1;
        end
      end
    end
  end

  function automatic int nextWinner(input logic [N-1:0] r, input int last_idx);
    int cand;
    nextWinner = -1;
    for (int off = N; off >= 1; off--) begin
      cand = (last_idx + off) % N;
      if (r[cand]) nextWinner = cand;
    end
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0 && i < N) v[i] = 1'b1;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic setWord(input int i, input logic [DW-1:0] w);
    req_data[i*DW +: DW] = w;
  endtask

  task automatic pushExpect(input logic [N-1:0] r);
    exp_t e;
    e.idx = nextWinner(r, model_last);
    if (e.idx >= 0) begin
      e.word = req_data[e.idx*DW +: DW];
      sb.push_back(e);
      model_last = e.idx;
    end
  endtask

  // Drive a request pattern and queue the launches it should produce.
  task automatic applyStimulus(input logic [N-1:0] r, input int launches);
    req = r;
    for (int k = 0; k < launches; k++) pushExpect(r);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_grant"}, grant, '0);
    checkOutput({tag, "_done"}, done, '0);
    checkOutput({tag, "_err"}, err, 1'b0);
    checkOutput({tag, "_start"}, p2s_start, 1'b0);
    checkOutput({tag, "_data"}, p2s_data, '0);
    checkOutput({tag, "_sel"}, sel, '0);
  endtask

  task automatic waitStart(input string tag, output int idx);
    int   n;
    exp_t e;
    n   = 0;
    idx = -1;
    while (p2s_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_start_seen"}, p2s_start, 1'b1);
    checkOutput({tag, "_sb_pending"}, sb.size() > 0, 1'b1);
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      idx = e.idx;
      checkOutput({tag, "_data"}, p2s_data, e.word);
      checkOutput({tag, "_grant"}, grant, onehot(e.idx));
      checkOutput({tag, "_sel"}, sel, e.idx);
    end
    start_cyc = cyc;
    @(negedge clk);
    checkOutput({tag, "_start_pulse"}, p2s_start, 1'b0);
  endtask

  task automatic waitDone(input string tag, input int idx, input logic exp_err, input int exp_lat);
    int n;
    n = 0;
    while (done === '0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_done"}, done, onehot(idx));
    checkOutput({tag, "_err"}, err, exp_err);
    checkOutput({tag, "_grant_clr"}, grant, '0);
    checkOutput({tag, "_latency"}, cyc - start_cyc, exp_lat);
    if (!exp_err) checkOutput({tag, "_fin2done"}, cyc - fin_cyc, 2);
  endtask

  initial begin
    int idx;
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst_n      = 1'b1;
    model_last = N - 1;

    // Single transfer from requester 0.
    @(negedge clk);
    fin_delay = 40;
    setWord(0, 32'hDEAD_BEEF);
    applyStimulus(3'b001, 1);
    waitStart("single", idx);
    waitDone("single", idx, 1'b0, 43);
    req = '0;
    @(negedge clk);
    checkOutput("single_done_pulse", done, '0);
    repeat (2) @(negedge clk);
    checkOutput("single_idle_start", p2s_start, 1'b0);

    // Two requesters held continuously alternate after a fresh reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n      = 1'b1;
    model_last = N - 1;
    fin_delay  = 5;
    setWord(0, 32'h1);
    setWord(1, 32'h2);
    applyStimulus(3'b011, 4);
    for (int k = 0; k < 4; k++) begin
      waitStart("alt", idx);
      waitDone("alt", idx, 1'b0, 8);
    end
    req = '0;
    @(negedge clk);

    // Last owner 2, requesters 1 and 2 pending: order is 1, 2, 1.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n      = 1'b1;
    model_last = N - 1;
    setWord(1, 32'hA1);
    setWord(2, 32'hA2);
    applyStimulus(3'b110, 3);
    for (int k = 0; k < 3; k++) begin
      waitStart("rr3", idx);
      waitDone("rr3", idx, 1'b0, 8);
    end
    req = '0;
    @(negedge clk);

    // Word is captured at launch; later data changes and req drop are ignored.
    fin_delay = 20;
    setWord(0, 32'hCAFE_0001);
    applyStimulus(3'b001, 1);
    waitStart("capture", idx);
    setWord(0, 32'hFFFF_0000);
    @(negedge clk);
    checkOutput("capture_hold", p2s_data, 32'hCAFE_0001);
    req = '0;
    waitDone("capture", idx, 1'b0, 23);
    checkOutput("capture_hold_done", p2s_data, 32'hCAFE_0001);
    @(negedge clk);

    // Converter never finishes: abort, then serve the pending requester.
    fin_delay = 0;
    setWord(0, 32'h55);
    applyStimulus(3'b001, 1);
    waitStart("timeout", idx);
    setWord(1, 32'h66);
    applyStimulus(3'b011, 1);
    waitDone("timeout", idx, 1'b1, TO + 1);
    req       = 3'b010;
    fin_delay = 3;
    waitStart("pending", idx);
    waitDone("pending", idx, 1'b0, 6);
    req = '0;
    @(negedge clk);

    // Finish on the watchdog's final cycle still succeeds; one cycle later aborts.
    fin_delay = TO - 2;
    setWord(2, 32'h77);
    applyStimulus(3'b100, 1);
    waitStart("edge_ok", idx);
    waitDone("edge_ok", idx, 1'b0, TO + 1);
    req = '0;
    @(negedge clk);
    fin_delay = TO - 1;
    applyStimulus(3'b100, 1);
    waitStart("edge_late", idx);
    waitDone("edge_late", idx, 1'b1, TO + 1);
    req = '0;
    repeat (2) @(negedge clk);
    checkOutput("edge_late_no_done", done, '0);
    checkOutput("edge_late_idle", p2s_start, 1'b0);

    // Reset in the middle of a transfer.
    fin_delay = 30;
    setWord(1, 32'h1234_5678);
    applyStimulus(3'b010, 1);
    waitStart("midrst", idx);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    req   = 3'b011;
    #1;
    checkResetValues("midrst_async");
    @(negedge clk);
    checkOutput("midrst_no_done", done, '0);
    rst_n = 1'b1;
    sb.delete();
    model_last = N - 1;
    setWord(0, 32'h0BAD_F00D);
    pushExpect(3'b011);
    waitStart("after_rst", idx);
    waitDone("after_rst", idx, 1'b0, 33);
    req = '0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
